fft_top_mul_scale: RTL
======================

FFT_TOP_MUL_SCALE -- requirements
Module: fft_top_mul_scale

Interface
REQ-001 Parameter A_W, default 22: signed multiplicand width.
REQ-002 Parameter B_W, default 15: unsigned multiplier width (twiddle/gain magnitude, Q0.B_W).
REQ-003 Parameter SHIFT, default 15: arithmetic right shift applied to the full product, range 0..A_W+B_W-2.
REQ-004 Parameter OUT_W, default 22: signed result width, OUT_W <= A_W+B_W+1-SHIFT.
REQ-005 Parameter PIPE, default 3: input-to-output latency in enabled cycles, minimum 3.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ce  in  1  clock enable; low freezes every pipeline register, including valid bits.
REQ-009 in_valid  in  1  qualifies din0/din1 in a cycle where ce=1.
REQ-010 din0  in  A_W  signed operand.
REQ-011 din1  in  B_W  unsigned operand, zero-extended before multiplication.
REQ-012 out_valid  out  1  dout holds a result.
REQ-013 dout  out  OUT_W  rounded, scaled, range-limited product.
REQ-014 ovf  out  1  registered with dout; high when the result exceeded OUT_W range.
REQ-015 ovf_sticky  out  1  set by any ovf with out_valid=1; held until cleared.
REQ-016 ovf_clr  in  1  clears ovf_sticky, independent of ce.

Function
REQ-017 Full product SHALL be signed(din0) * signed({1'b0,din1}), A_W+B_W+1 bits, exact.
REQ-018 Scaling SHALL be full >>> SHIFT with round-half-to-even on the discarded bits; SHIFT=0 bypasses rounding.
REQ-019 Rounding SHALL be performed at one bit of extra width so that rounding carry cannot wrap before range check.
REQ-020 ovf SHALL be 1 when the rounded value lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 Stage 1 registers operands, stage 2 registers the product, stage 3 registers round/range result; PIPE>3 appends PIPE-3 delay stages on dout/ovf/out_valid.
REQ-022 A sample accepted with ce=1, in_valid=1 SHALL appear on dout with out_valid=1 exactly PIPE ce-high cycles later; ce-low cycles do not count.
REQ-023 Data registers SHALL load regardless of in_valid; out_valid SHALL be the in_valid delayed by PIPE enabled cycles.
REQ-024 Back-to-back inputs SHALL be accepted every ce-high cycle (throughput 1/cycle).
REQ-025 ovf_clr and a new overflow in the same cycle: set wins (sticky stays 1).
REQ-026 ovf_sticky SHALL update only when ce=1 for set; ovf_clr acts whenever asserted.

Reset
REQ-027 reset=1 SHALL clear out_valid, all in-flight valid bits, dout, ovf, ovf_sticky and all data registers to 0 on the next edge, regardless of ce.
REQ-028 Samples in flight at reset SHALL be discarded; no out_valid pulse follows reset for them.
REQ-029 First input accepted in the cycle after reset deasserts SHALL emerge normally after PIPE cycles.

Configuration
REQ-030 With FFT_TOP_MUL_SAT_EN defined, out-of-range results SHALL clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
REQ-031 Without FFT_TOP_MUL_SAT_EN, dout SHALL be the low OUT_W bits of the rounded value (wrap); ovf and ovf_sticky behave identically in both builds.

Structure
REQ-032 Package fft_top_mul_pkg SHALL hold default widths (A_W, B_W, SHIFT, OUT_W, PIPE) and the minimum-PIPE constant.
REQ-033 Combinational rounding/range logic SHALL be a sub-module fft_top_round_sat (inputs: wide value; outputs: OUT_W result, ovf), instantiated between stages 2 and 3.
REQ-034 Product stage SHALL be a plain registered multiply suitable for DSP48 inference, without reset on the multiplier output when the synthesis attribute requires it, but still zero after REQ-027 at the dout boundary.

Verification (defaults unless stated)
REQ-035 din0=1000, din1=16384, in_valid=1 -> dout=500, ovf=0, out_valid exactly 3 cycles later.
REQ-036 Rounding: din1=16384 with din0=1,3,5 -> dout=0,2,2 (ties to even); din0=-3 -> -2.
REQ-037 SHIFT=13: din0=2097151, din1=32767 -> SAT_EN build dout=2097151; wrap build dout=-260; both ovf=1, ovf_sticky=1 until ovf_clr pulse.
REQ-038 Stream of 8 samples with ce toggled 1,0,1,0... -> outputs in order, each after 3 ce-high cycles, values held while ce=0.
REQ-039 reset asserted with 2 samples in flight -> out_valid stays 0 for the next 5 cycles; sample issued after reset deasserts appears with latency 3.
REQ-040 PIPE=5, ovf_clr coincident with new overflow -> latency 5, ovf_sticky remains 1.

Source files
------------

// File: rtl/fft_top_mul_pkg.sv
// Shared defaults for the scaled multiplier: operand/result widths, shift and latency.
package fft_top_mul_pkg;

  localparam int A_W_DEF   = 22;
  localparam int B_W_DEF   = 15;
  localparam int SHIFT_DEF = 15;
  localparam int OUT_W_DEF = 22;
  localparam int PIPE_DEF  = 3;
  localparam int PIPE_MIN  = 3;

endpackage

// File: rtl/fft_top_round_sat.sv
// Round-half-to-even right shift of a wide signed value, then range check to OUT_W bits.
// Out-of-range handling: clamp when FFT_TOP_MUL_SAT_EN is defined, otherwise wrap.
module fft_top_round_sat #(
  parameter int IN_W  = 38,
  parameter int SHIFT = 15,
  parameter int OUT_W = 22
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    ovf_o
);

  // One spare bit above the shifted value so a rounding carry never wraps.
  localparam int Q_W = IN_W - SHIFT + 1;

  logic signed [Q_W-1:0] rnd;

  generate
    if (SHIFT == 0) begin : g_nornd
      assign rnd = {val_i[IN_W-1], val_i};
    end else begin : g_rnd
      localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
      logic signed [IN_W-SHIFT-1:0] q;
      logic        [SHIFT-1:0]      rem;
      logic                         up;
      assign q   = val_i[IN_W-1:SHIFT];
      assign rem = val_i[SHIFT-1:0];
      assign up  = (rem > HALF) || ((rem == HALF) && q[0]);
      assign rnd = {q[IN_W-SHIFT-1], q} + {{(Q_W-1){1'b0}}, up};
    end
  endgenerate

  function automatic logic out_of_range(input logic signed [Q_W-1:0] v);
    logic [Q_W-OUT_W:0] top;
    top = v[Q_W-1:OUT_W-1];
    return !((&top) || !(|top));
  endfunction

  assign ovf_o = out_of_range(rnd);

`ifdef FFT_TOP_MUL_SAT_EN
  function automatic logic signed [OUT_W-1:0] clamp(input logic signed [Q_W-1:0] v,
                                                    input logic o);
    if (!o)
      return v[OUT_W-1:0];
    else if (v[Q_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign res_o = clamp(rnd, ovf_o);
`else
  assign res_o = rnd[OUT_W-1:0];
`endif

endmodule

// File: rtl/fft_top_mul_scale.sv
// Pipelined signed x unsigned multiply with rounded arithmetic shift and range limiting.
// Optional clamping of out-of-range results via FFT_TOP_MUL_SAT_EN (wrap when undefined).
module fft_top_mul_scale
  import fft_top_mul_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int PIPE  = PIPE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   din0,
  input  logic        [B_W-1:0]   din1,
  input  logic                    ovf_clr,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf,
  output logic                    ovf_sticky
);

  localparam int FULL_W = A_W + B_W + 1;
  localparam int DLY    = PIPE - PIPE_MIN + 1;

  logic signed [A_W-1:0]    a_p1_q;
  logic        [B_W-1:0]    b_p1_q;
  logic                     vld_p1_q;
  logic signed [FULL_W-1:0] prod_p2_d;
  logic signed [FULL_W-1:0] prod_p2_q;
  logic                     vld_p2_q;
  logic signed [OUT_W-1:0]  rnd_p3_d;
  logic                     ovf_p3_d;

  logic signed [OUT_W-1:0]  dout_sr_d [DLY];
  logic signed [OUT_W-1:0]  dout_sr_q [DLY];
  logic                     ovf_sr_d  [DLY];
  logic                     ovf_sr_q  [DLY];
  logic                     vld_sr_d  [DLY];
  logic                     vld_sr_q  [DLY];
  logic                     sticky_d;
  logic                     sticky_q;

  // Stage 1: operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      vld_p1_q <= 1'b0;
    end else if (ce) begin
      a_p1_q   <= din0;
      b_p1_q   <= din1;
      vld_p1_q <= in_valid;
    end
  end

  // Stage 2: exact product, unsigned operand zero-extended into the signed domain
  assign prod_p2_d = FULL_W'(a_p1_q) * FULL_W'($signed({1'b0, b_p1_q}));

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else if (ce) begin
      prod_p2_q <= prod_p2_d;
      vld_p2_q  <= vld_p1_q;
    end
  end

  fft_top_round_sat #(
    .IN_W  (FULL_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .val_i (prod_p2_q),
    .res_o (rnd_p3_d),
    .ovf_o (ovf_p3_d)
  );

  // Stage 3 and optional trailing delay stages share one shift register
  assign dout_sr_d[0] = rnd_p3_d;
  assign ovf_sr_d[0]  = ovf_p3_d;
  assign vld_sr_d[0]  = vld_p2_q;

  generate
    for (genvar k = 1; k < DLY; k++) begin : g_dly
      assign dout_sr_d[k] = dout_sr_q[k-1];
      assign ovf_sr_d[k]  = ovf_sr_q[k-1];
      assign vld_sr_d[k]  = vld_sr_q[k-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DLY; k++) begin
        dout_sr_q[k] <= '0;
        ovf_sr_q[k]  <= 1'b0;
        vld_sr_q[k]  <= 1'b0;
      end
    end else if (ce) begin
      for (int k = 0; k < DLY; k++) begin
        dout_sr_q[k] <= dout_sr_d[k];
        ovf_sr_q[k]  <= ovf_sr_d[k];
        vld_sr_q[k]  <= vld_sr_d[k];
      end
    end
  end

  // Sticky sets on the same edge a valid overflowing result reaches the output; set beats clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ce && vld_sr_d[DLY-1] && ovf_sr_d[DLY-1])
      sticky_d = 1'b1;
    else if (ovf_clr)
      sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      sticky_q <= 1'b0;
    else
      sticky_q <= sticky_d;
  end

  assign out_valid  = vld_sr_q[DLY-1];
  assign dout       = dout_sr_q[DLY-1];
  assign ovf        = ovf_sr_q[DLY-1];
  assign ovf_sticky = sticky_q;

endmodule
